// File: rtl/apb_master.sv
`timescale 1ns/1ps
// apb_master: APB requester for a two-slave APB segment.
//   Takes single read/write commands on a valid/ready port, decodes the
//   address MSB into PSEL1/PSEL2, runs the SETUP/ACCESS sequence and returns
//   a one-cycle response strobe carrying read data or a timeout error.
// Ports:
//   PCLK, PRESETn            clock, synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write/addr/wdata     command payload
//   rsp_valid/rdata/err      one-cycle completion strobe with held payload
//   PSEL1/PSEL2/PENABLE/PWRITE/PADDR/PWDATA  APB request signals
//   PRDATA/PREADY            merged return path from the slave multiplexer
module apb_master #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 16,
  parameter int TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 PSEL1,
  output logic                 PSEL2,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0] PWDATA,
  input  logic [DATAWIDTH-1:0] PRDATA,
  input  logic                 PREADY
);

  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  // Counter value seen on the edge that would be the TIMEOUT-th wait edge.
  localparam logic [CNTW-1:0] CNT_LAST = TO_EN ? CNTW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 psel1_q, psel1_d;
  logic                 psel2_q, psel2_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
  logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
  logic                 timeout_hit_s;

  assign timeout_hit_s = TO_EN && (cnt_q == CNT_LAST);

  // Next-state and next-output computation for the IDLE/SETUP/ACCESS sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d     = ST_SETUP;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          psel1_d     = ~cmd_addr[ADDRWIDTH-1];
          psel2_d     = cmd_addr[ADDRWIDTH-1];
          penable_d   = 1'b0;
        end else begin
          cmd_ready_d = 1'b1;
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // PREADY is tested first so a ready on the timeout edge completes normally.
        if (PREADY) begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
        end else if (timeout_hit_s) begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
        end else begin
          cnt_d = TO_EN ? (cnt_q + CNTW'(1)) : cnt_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        psel1_d     = 1'b0;
        psel2_d     = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
`timescale 1ns/1ps
// tb_apb_master: directed plus randomized bench for apb_master (TIMEOUT=4).
// A transaction-level model predicts, per command, the number of ACCESS
// cycles, the error flag and the returned data; the bench acts as the slave.
module tb_apb_master;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL1, PSEL2, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  int checks = 0;
  int failures = 0;

  // Expected held response payload and the next command for held-valid tests.
  logic [DW-1:0] last_rdata = 32'h0;
  logic          last_err = 1'b0;
  logic          nxt_w;
  logic [AW-1:0] nxt_a;
  logic [DW-1:0] nxt_wd;

  always #5 PCLK = ~PCLK;

  apb_master #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
    chk({tag, "_psel1"},     {31'd0, PSEL1}, 32'd0);
    chk({tag, "_psel2"},     {31'd0, PSEL2}, 32'd0);
    chk({tag, "_penable"},   {31'd0, PENABLE}, 32'd0);
    chk({tag, "_pwrite"},    {31'd0, PWRITE}, 32'd0);
    chk({tag, "_paddr"},     {16'd0, PADDR}, 32'd0);
    chk({tag, "_pwdata"},    PWDATA, 32'd0);
  endtask

  // Idle cycle that is not a response cycle: bus quiet, response payload held.
  task automatic check_idle(input string tag);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_psel"},      {30'd0, PSEL2, PSEL1}, 32'd0);
    chk({tag, "_penable"},   {31'd0, PENABLE}, 32'd0);
    chk({tag, "_rdata_hold"}, rsp_rdata, last_rdata);
    chk({tag, "_err_hold"},  {31'd0, rsp_err}, {31'd0, last_err});
  endtask

  // One complete transfer, starting in a cycle where cmd_ready is expected high
  // and ending in the response cycle. waits = PREADY-low ACCESS cycles offered.
  task automatic do_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int waits, input logic [DW-1:0] rd, input bit hold);
    int            n_acc;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    logic          exp_p1;
    logic          exp_p2;
    exp_err = (waits >= TO);
    n_acc   = exp_err ? TO : waits + 1;
    exp_rd  = (w || exp_err) ? 32'h0 : rd;
    exp_p2  = a[AW-1];
    exp_p1  = (a[AW-1] == 1'b0);

    chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = wd;
    tick();
    if (hold) begin
      cmd_write = nxt_w;
      cmd_addr  = nxt_a;
      cmd_wdata = nxt_wd;
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = 16'($urandom);
      cmd_wdata = $urandom;
    end
    // SETUP cycle
    chk("setup_psel1",   {31'd0, PSEL1}, {31'd0, exp_p1});
    chk("setup_psel2",   {31'd0, PSEL2}, {31'd0, exp_p2});
    chk("setup_penable", {31'd0, PENABLE}, 32'd0);
    chk("setup_ready",   {31'd0, cmd_ready}, 32'd0);
    chk("setup_rsp",     {31'd0, rsp_valid}, 32'd0);
    chk("setup_paddr",   {16'd0, PADDR}, {16'd0, a});
    chk("setup_pwrite",  {31'd0, PWRITE}, {31'd0, w});
    chk("setup_pwdata",  PWDATA, wd);
    PREADY = 1'($urandom);
    PRDATA = $urandom;
    for (int k = 0; k < n_acc; k++) begin
      tick();
      chk("acc_penable", {31'd0, PENABLE}, 32'd1);
      chk("acc_psel1",   {31'd0, PSEL1}, {31'd0, exp_p1});
      chk("acc_psel2",   {31'd0, PSEL2}, {31'd0, exp_p2});
      chk("acc_paddr",   {16'd0, PADDR}, {16'd0, a});
      chk("acc_pwrite",  {31'd0, PWRITE}, {31'd0, w});
      chk("acc_pwdata",  PWDATA, wd);
      chk("acc_ready",   {31'd0, cmd_ready}, 32'd0);
      chk("acc_rsp",     {31'd0, rsp_valid}, 32'd0);
      PREADY = (k == waits);
      PRDATA = (k == waits) ? rd : $urandom;
    end
    tick();
    PREADY = 1'($urandom);
    PRDATA = $urandom;
    chk("rsp_valid",   {31'd0, rsp_valid}, 32'd1);
    chk("rsp_err",     {31'd0, rsp_err}, {31'd0, exp_err});
    chk("rsp_rdata",   rsp_rdata, exp_rd);
    chk("rsp_psel",    {30'd0, PSEL2, PSEL1}, 32'd0);
    chk("rsp_penable", {31'd0, PENABLE}, 32'd0);
    chk("rsp_ready",   {31'd0, cmd_ready}, 32'd1);
    last_rdata = exp_rd;
    last_err   = exp_err;
  endtask

  initial begin
    logic          cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cwd;
    int            gap;

    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_wdata = 32'h0;
    PREADY = 1'b0; PRDATA = 32'h0;
    nxt_w = 1'b0; nxt_a = 16'h0; nxt_wd = 32'h0;
    tick();
    tick();
    check_reset_state("reset");
    PRESETn = 1'b1;
    tick();
    check_idle("post_reset");

    // Write to slave 1, no wait states.
    do_xfer(1'b1, 16'h0010, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    tick();
    check_idle("idle_after_write");

    // Read from slave 2, three wait states; PREADY lands on the 4th (timeout) edge.
    do_xfer(1'b0, 16'h8004, 32'h0, 3, 32'h12345678, 1'b0);
    tick();
    check_idle("idle_after_read");

    // Timeout: PREADY never rises.
    do_xfer(1'b0, 16'h0020, 32'h0, 100, 32'hCAFEF00D, 1'b0);
    tick();
    check_idle("idle_after_timeout");

    // Back-to-back with cmd_valid held: write 0x0000 then read 0x8000.
    nxt_w = 1'b0; nxt_a = 16'h8000; nxt_wd = 32'h0;
    do_xfer(1'b1, 16'h0000, 32'hA5A5A5A5, 0, 32'h0, 1'b1);
    do_xfer(1'b0, 16'h8000, 32'h0, 0, 32'h0BADCAFE, 1'b0);
    tick();
    check_idle("idle_after_b2b");

    // Reset in the middle of ACCESS wait states.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h8010; cmd_wdata = 32'h55AA55AA;
    tick();
    cmd_valid = 1'b0;
    PREADY = 1'b0;
    tick();
    tick();
    chk("midrst_in_access", {31'd0, PENABLE}, 32'd1);
    PRESETn = 1'b0;
    tick();
    check_reset_state("midrst");
    PRESETn = 1'b1;
    last_rdata = 32'h0;
    last_err = 1'b0;
    tick();
    check_idle("midrst_after1");
    tick();
    check_idle("midrst_after2");
    do_xfer(1'b0, 16'h8044, 32'h0, 1, 32'h13579BDF, 1'b0);
    tick();
    check_idle("idle_after_midrst");

    // Randomized commands, wait states and inter-command gaps.
    cw = 1'($urandom); ca = 16'($urandom); cwd = $urandom;
    for (int i = 0; i < 24; i++) begin
      nxt_w  = 1'($urandom);
      nxt_a  = 16'($urandom);
      nxt_wd = $urandom;
      gap    = $urandom_range(0, 2);
      do_xfer(cw, ca, cwd, $urandom_range(0, 6), $urandom, (gap == 0));
      for (int g = 0; g < gap; g++) begin
        tick();
        check_idle("rand_idle");
      end
      cw = nxt_w; ca = nxt_a; cwd = nxt_wd;
    end
    cmd_valid = 1'b0;
    tick();
    check_idle("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
